// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller for ImmGen: valid/ready intake, opcode -> immSel decode,
// one pipeline register for immIn/immSel, halt on illegal opcode. Optional: ID_PERF_CNT_EN.
module imm_decode_ctrl #(
`ifdef ID_PERF_CNT_EN
    parameter int CNT_WIDTH     = 16,
`endif
    parameter int INST_LENGTH   = 32,
    parameter int OPCODE_LENGTH = 7,
    parameter int IMMIN_LENGTH  = INST_LENGTH - OPCODE_LENGTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INST_LENGTH-1:0]  inst_in,
    input  logic                    inst_valid,
    output logic                    inst_ready,
    input  logic                    flush,
    input  logic                    resume,
    output logic [IMMIN_LENGTH-1:0] immIn,
    output logic [2:0]              immSel,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic                    illegal,
    output logic                    halted
`ifdef ID_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    perf_dec_cnt
`endif
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    localparam logic [OPCODE_LENGTH-1:0] OP_R     = 7'b0110011;
    localparam logic [OPCODE_LENGTH-1:0] OP_I_ALU = 7'b0010011;
    localparam logic [OPCODE_LENGTH-1:0] OP_I_LD  = 7'b0000011;
    localparam logic [OPCODE_LENGTH-1:0] OP_B     = 7'b1100011;
    localparam logic [OPCODE_LENGTH-1:0] OP_S     = 7'b0100011;
    localparam logic [OPCODE_LENGTH-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPCODE_LENGTH-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OPCODE_LENGTH-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPCODE_LENGTH-1:0] OP_JALR  = 7'b1100111;

    state_e                  state_q, state_d;
    logic                    dec_valid_q, dec_valid_d;
    logic [IMMIN_LENGTH-1:0] imm_in_q, imm_in_d;
    logic [2:0]              imm_sel_q, imm_sel_d;
    logic                    illegal_q, illegal_d;

    logic       accept;
    logic       consume;
    logic       op_legal;
    logic [2:0] op_sel;

    // NOTE: every signal written in always_comb gets a default first; a missing
    // branch assignment would otherwise infer a latch.
    always_comb begin
        op_legal = 1'b1;
        op_sel   = 3'b000;
        case (inst_in[OPCODE_LENGTH-1:0])
            OP_R:              op_sel = 3'b000;
            OP_I_ALU, OP_I_LD: op_sel = 3'b001;
            OP_B:              op_sel = 3'b010;
            OP_S:              op_sel = 3'b011;
            OP_LUI:            op_sel = 3'b100;
            OP_AUIPC:          op_sel = 3'b101;
            OP_JAL:            op_sel = 3'b110;
            OP_JALR:           op_sel = 3'b111;
            default:           op_legal = 1'b0;
        endcase
    end

    assign inst_ready = (state_q == S_RUN) && (!dec_valid_q || dec_ready);
    assign accept     = inst_valid && inst_ready;
    assign consume    = dec_valid_q && dec_ready;

    // flush outranks accept and consume; an illegal accept keeps the old immIn/immSel.
    always_comb begin
        state_d     = state_q;
        dec_valid_d = dec_valid_q;
        imm_in_d    = imm_in_q;
        imm_sel_d   = imm_sel_q;
        illegal_d   = 1'b0;

        if (flush) begin
            dec_valid_d = 1'b0;
        end else if (accept && op_legal) begin
            dec_valid_d = 1'b1;
            imm_in_d    = inst_in[INST_LENGTH-1:OPCODE_LENGTH];
            imm_sel_d   = op_sel;
        end else if (accept) begin
            dec_valid_d = 1'b0;
            illegal_d   = 1'b1;
            state_d     = S_HALT;
        end else if (consume) begin
            dec_valid_d = 1'b0;
        end

        if (state_q == S_HALT && resume) begin
            state_d = S_RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            dec_valid_q <= 1'b0;
            imm_in_q    <= '0;
            imm_sel_q   <= 3'b000;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_valid_q <= dec_valid_d;
            imm_in_q    <= imm_in_d;
            imm_sel_q   <= imm_sel_d;
            illegal_q   <= illegal_d;
        end
    end

    assign immIn     = imm_in_q;
    assign immSel    = imm_sel_q;
    assign dec_valid = dec_valid_q;
    assign illegal   = illegal_q;
    assign halted    = (state_q == S_HALT);

`ifdef ID_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] perf_cnt_q, perf_cnt_d;

    // Counts legal loads only; wraps naturally at 2^CNT_WIDTH.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (accept && op_legal && !flush) begin
            perf_cnt_d = perf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_dec_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed self-checking bench for imm_decode_ctrl; perf counter test runs when
// ID_PERF_CNT_EN is defined (counter built 4 bits wide to exercise wrap).
`timescale 1ns/1ps
module tb_imm_decode_ctrl;

`ifdef ID_PERF_CNT_EN
    localparam int CW = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        inst_ready;
    logic        flush;
    logic        resume;
    logic [24:0] immIn;
    logic [2:0]  immSel;
    logic        dec_valid;
    logic        dec_ready;
    logic        illegal;
    logic        halted;
`ifdef ID_PERF_CNT_EN
    logic [CW-1:0] perf_dec_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

`ifdef ID_PERF_CNT_EN
    imm_decode_ctrl #(.CNT_WIDTH(CW)) dut (
`else
    imm_decode_ctrl dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .flush      (flush),
        .resume     (resume),
        .immIn      (immIn),
        .immSel     (immSel),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .illegal    (illegal),
`ifdef ID_PERF_CNT_EN
        .perf_dec_cnt(perf_dec_cnt),
`endif
        .halted     (halted)
    );

    // Advance one clock; outputs are then sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected immIn for an instruction word: bits [31:7].
    function automatic logic [24:0] upper(input logic [31:0] inst);
        return inst[31:7];
    endfunction

    task automatic test_reset();
        rst = 1'b1; inst_in = '0; inst_valid = 1'b0; flush = 1'b0;
        resume = 1'b0; dec_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({dec_valid, illegal, halted, immSel, immIn} !== 31'd0) begin
            tests_failed++;
            $display("FAIL reset_state got dv=%b ill=%b halt=%b sel=%b imm=%h want all zero",
                     dec_valid, illegal, halted, immSel, immIn);
        end
        tests_run++;
        if (inst_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready got %b want 1", inst_ready);
        end
`ifdef ID_PERF_CNT_EN
        tests_run++;
        if (perf_dec_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_perf got %0d want 0", perf_dec_cnt);
        end
`endif
    endtask

    task automatic test_addi();
        inst_in = 32'h0050_0093; inst_valid = 1'b1; dec_ready = 1'b0;
        step();
        tests_run++;
        if ({dec_valid, immSel, immIn} !== {1'b1, 3'b001, 25'h000A001}) begin
            tests_failed++;
            $display("FAIL addi_load got dv=%b sel=%b imm=%h want dv=1 sel=001 imm=000a001",
                     dec_valid, immSel, immIn);
        end
    endtask

    task automatic test_stall_then_stream();
        logic [31:0] vec [3];
        logic [2:0]  sel [3];
        vec[0] = 32'h1234_5033; sel[0] = 3'b000;
        vec[1] = 32'hABCD_E003; sel[1] = 3'b001;
        vec[2] = 32'h0FF0_A023; sel[2] = 3'b011;
        inst_in = vec[0]; inst_valid = 1'b1; dec_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({inst_ready, dec_valid, immSel, immIn} !== {1'b0, 1'b1, 3'b001, 25'h000A001}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d] got rdy=%b dv=%b sel=%b imm=%h want rdy=0 dv=1 sel=001 imm=000a001",
                         i, inst_ready, dec_valid, immSel, immIn);
            end
            step();
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_in = vec[i];
            #1;
            tests_run++;
            if (inst_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, inst_ready);
            end
            step();
            tests_run++;
            if ({dec_valid, immSel, immIn} !== {1'b1, sel[i], upper(vec[i])}) begin
                tests_failed++;
                $display("FAIL b2b_load[%0d] got dv=%b sel=%b imm=%h want dv=1 sel=%b imm=%h",
                         i, dec_valid, immSel, immIn, sel[i], upper(vec[i]));
            end
        end
        inst_valid = 1'b0;
        step();
        tests_run++;
        if (dec_valid !== 1'b0 || immIn !== upper(vec[2])) begin
            tests_failed++;
            $display("FAIL drain got dv=%b imm=%h want dv=0 imm=%h", dec_valid, immIn, upper(vec[2]));
        end
    endtask

    task automatic test_opcode_stream();
        logic [31:0] vec [6];
        logic [2:0]  sel [6];
        vec[0] = 32'h0080_006F; sel[0] = 3'b110;
        vec[1] = 32'h0000_80E7; sel[1] = 3'b111;
        vec[2] = 32'h1234_5537; sel[2] = 3'b100;
        vec[3] = 32'h0011_2623; sel[3] = 3'b011;
        vec[4] = 32'hFE00_0EE3; sel[4] = 3'b010;
        vec[5] = 32'h0000_0517; sel[5] = 3'b101;
        dec_ready = 1'b1; inst_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            inst_in = vec[i];
            step();
            tests_run++;
            if ({dec_valid, immSel, immIn} !== {1'b1, sel[i], upper(vec[i])}) begin
                tests_failed++;
                $display("FAIL opcode[%0d] got dv=%b sel=%b imm=%h want dv=1 sel=%b imm=%h",
                         i, dec_valid, immSel, immIn, sel[i], upper(vec[i]));
            end
        end
        inst_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal_halt();
        logic [24:0] held;
        held = upper(32'h0000_0517);
        inst_in = 32'h0000_007F; inst_valid = 1'b1; dec_ready = 1'b1;
        step();
        tests_run++;
        if ({illegal, halted, inst_ready, dec_valid} !== 4'b1100 || immIn !== held) begin
            tests_failed++;
            $display("FAIL illegal_accept got ill=%b halt=%b rdy=%b dv=%b imm=%h want 1 1 0 0 imm=%h",
                     illegal, halted, inst_ready, dec_valid, immIn, held);
        end
        inst_in = 32'h0000_0033;
        step();
        tests_run++;
        if ({illegal, halted, inst_ready, dec_valid} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL halt_hold got ill=%b halt=%b rdy=%b dv=%b want 0 1 0 0",
                     illegal, halted, inst_ready, dec_valid);
        end
        inst_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if (halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_in_halt got halted=%b want 1", halted);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        #1;
        tests_run++;
        if ({halted, inst_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL resume got halt=%b rdy=%b want 0 1", halted, inst_ready);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        tests_run++;
        if ({halted, illegal} !== 2'b00) begin
            tests_failed++;
            $display("FAIL resume_in_run got halt=%b ill=%b want 0 0", halted, illegal);
        end
    endtask

    task automatic test_flush();
        logic [24:0] held;
        held = upper(32'h0000_0517);
        inst_in = 32'hFE00_0EE3; inst_valid = 1'b1; flush = 1'b1; dec_ready = 1'b1;
        #1;
        tests_run++;
        if (inst_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_ready got %b want 1", inst_ready);
        end
        step();
        tests_run++;
        if ({dec_valid, illegal} !== 2'b00 || immIn !== held) begin
            tests_failed++;
            $display("FAIL flush_accept got dv=%b ill=%b imm=%h want 0 0 imm=%h",
                     dec_valid, illegal, immIn, held);
        end
        inst_in = 32'h0000_007F;
        step();
        tests_run++;
        if ({illegal, halted, dec_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL flush_illegal got ill=%b halt=%b dv=%b want 0 0 0",
                     illegal, halted, dec_valid);
        end
        flush = 1'b0; inst_in = 32'hFE00_0EE3;
        step();
        tests_run++;
        if ({dec_valid, immSel, immIn} !== {1'b1, 3'b010, upper(32'hFE00_0EE3)}) begin
            tests_failed++;
            $display("FAIL branch_load got dv=%b sel=%b imm=%h want dv=1 sel=010 imm=%h",
                     dec_valid, immSel, immIn, upper(32'hFE00_0EE3));
        end
        inst_valid = 1'b0; dec_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if (dec_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_staged got dv=%b want 0", dec_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        inst_in = 32'h1234_5537; inst_valid = 1'b1; dec_ready = 1'b0;
        step();
        inst_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if ({dec_valid, immSel, immIn, halted} !== 30'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_op got dv=%b sel=%b imm=%h halt=%b want all zero",
                     dec_valid, immSel, immIn, halted);
        end
    endtask

`ifdef ID_PERF_CNT_EN
    task automatic test_perf_count();
        rst = 1'b1;
        step();
        rst = 1'b0;
        inst_in = 32'h0050_0093; inst_valid = 1'b1; dec_ready = 1'b1;
        for (int i = 0; i < 17; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0; inst_valid = 1'b0;
        step();
        tests_run++;
        if (perf_dec_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL perf_wrap got %0d want 1", perf_dec_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_stall_then_stream();
        test_opcode_stream();
        test_illegal_halt();
        test_flush();
        test_reset_mid_op();
`ifdef ID_PERF_CNT_EN
        test_perf_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
